// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: state encodings and 12 MHz default timing constants for the button conditioner
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam int CLK_HZ              = 12_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    localparam int CNT_W_DEF           = 17;
    localparam int HOLD_CYCLES_DEF     = CLK_HZ;
    localparam int HOLD_W_DEF          = 24;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with synchronous reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, invert and debounce an active-low button; optional long-press via BUTTON_CONDITIONER_LONG_PRESS_EN
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int HOLD_W          = HOLD_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             s;
    logic             level_n, press_n, release_n;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (~btn_n),
        .q   (s)
    );

    // next-state, debounce counter and registered-output values
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = btn_level;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_n = DB_PRESS;
                    cnt_n   = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = PRESSED;
                    level_n = 1'b1;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = DB_RELEASE;
                    cnt_n   = '0;
                end
            end
            DB_RELEASE: begin
                if (s) begin
                    state_n = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            btn_level     <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              long_n;

    // hold counter: cleared on a fresh press or on return to idle, saturating while held
    always_comb begin
        hold_n = hold_cnt;
        long_n = 1'b0;
        if (state_n == IDLE || (state == DB_PRESS && state_n == PRESSED)) begin
            hold_n = '0;
        end else if ((state == PRESSED || state == DB_RELEASE) && hold_cnt != HOLD_LAST) begin
            hold_n = hold_cnt + HOLD_W'(1);
            long_n = (hold_n == HOLD_LAST);
        end
    end

    // hold counter and long-press pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            hold_cnt   <= hold_n;
            long_press <= long_n;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven and directed checks of the button conditioner
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;
    logic lvl, pp, rp, lp;
    logic lvl1, pp1, rp1, lp1;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .HOLD_CYCLES     (20),
        .HOLD_W          (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .btn_level     (lvl),
        .press_pulse   (pp),
        .release_pulse (rp),
        .long_press    (lp)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (1),
        .HOLD_CYCLES     (20),
        .HOLD_W          (5)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .btn_level     (lvl1),
        .press_pulse   (pp1),
        .release_pulse (rp1),
        .long_press    (lp1)
    );

    typedef struct {
        bit rst;
        bit btn_n;
        bit lvl;
        bit pp;
        bit rp;
        bit lp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input bit r, input bit b, input int n, input bit l, input bit p, input bit q, input bit g = 1'b0);
        vec_t v;
        v = '{r, b, l, p, q, g};
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit b);
        rst   = r;
        btn_n = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with button released, then reset while the button is already held
        add(1, 1, 3, 0, 0, 0);
        add(1, 0, 2, 0, 0, 0);
        // held through reset release: press at the 6th edge, then held 20 cycles total
        add(0, 0, 6, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 13, 1, 0, 0);
        // clean release: release_pulse and level drop together at the 6th edge
        add(0, 1, 6, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 3, 0, 0, 0);
        // press bounce: low 3, high 2, low 3, then high
        add(0, 0, 3, 0, 0, 0);
        add(0, 1, 2, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0);
        add(0, 1, 8, 0, 0, 0);
        // fresh press, then a 2-cycle release glitch, then a long hold
        add(0, 0, 6, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 3, 1, 0, 0);
        add(0, 1, 2, 1, 0, 0);
        add(0, 0, 14, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, LP);
        add(0, 0, 15, 1, 0, 0);
        add(0, 1, 6, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 4, 0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].btn_n);
            check($sformatf("vec%0d btn_level", i), lvl, vecs[i].lvl);
            check($sformatf("vec%0d press_pulse", i), pp, vecs[i].pp);
            check($sformatf("vec%0d release_pulse", i), rp, vecs[i].rp);
            check($sformatf("vec%0d long_press", i), lp, vecs[i].lp);
        end

        // reset mid-debounce: reach DB_PRESS with cnt=2, then reset while held
        for (int k = 0; k < 5; k++) begin
            tick(0, 0);
            check($sformatf("mid pre%0d press_pulse", k), pp, 1'b0);
            check($sformatf("mid pre%0d btn_level", k), lvl, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1, 0);
            check($sformatf("mid rst%0d press_pulse", k), pp, 1'b0);
            check($sformatf("mid rst%0d btn_level", k), lvl, 1'b0);
            check($sformatf("mid rst%0d d1 press_pulse", k), pp1, 1'b0);
            check($sformatf("mid rst%0d d1 btn_level", k), lvl1, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            tick(0, 0);
            check($sformatf("mid post%0d press_pulse", k), pp, k == 6);
            check($sformatf("mid post%0d btn_level", k), lvl, k >= 6);
            check($sformatf("mid post%0d d1 press_pulse", k), pp1, k == 3);
            check($sformatf("mid post%0d d1 btn_level", k), lvl1, k >= 3);
        end

        // single-cycle debounce release latency on the short instance
        for (int k = 0; k < 5; k++) begin
            tick(0, 1);
            check($sformatf("d1 rel%0d release_pulse", k), rp1, k == 3);
            check($sformatf("d1 rel%0d btn_level", k), lvl1, k < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions one raw active-low push-button into clean, glitch-free control signals for the downstream counting FSM. The block sits directly upstream of that FSM on the icestick design. It synchronises the pad input, inverts it, and debounces it with a four-state machine. Its outputs are a stable pressed level and one-cycle press/release pulses, plus an optional long-press pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: cycles the synchronised input must stay stable before a level change is accepted (10 ms at 12 MHz). Must be ≥ 1.
- `CNT_W`, default 17: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `HOLD_CYCLES`, default 12000000: cycles after `press_pulse` at which `long_press` fires (1 s). Used only with the macro.
- `HOLD_W`, default 24: hold counter width. Must satisfy 2^HOLD_W > HOLD_CYCLES.
- `clk` in 1: system clock, 12 MHz. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_n` in 1: raw button pad, active-low, asynchronous to `clk`.
- `btn_level` out 1: debounced pressed state (1 = pressed).
- `press_pulse` out 1: high for exactly one cycle when a press is accepted.
- `release_pulse` out 1: high for exactly one cycle when a release is accepted.
- `long_press` out 1: high for one cycle once per press after a long hold. The port always exists and is tied 0 without the macro.

## Operation
- Input path: `btn_n` is inverted, then passed through a 2-flop synchroniser to give `s` (1 = pressed).
- FSM states (2-bit): IDLE=0, DB_PRESS=1, PRESSED=2, DB_RELEASE=3.
- IDLE: if `s`=1, go to DB_PRESS with cnt←0.
- DB_PRESS:
  - If `s`=0, return to IDLE (bounce rejected, no outputs).
  - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, set `btn_level`←1, and pulse `press_pulse`.
  - Else cnt←cnt+1.
- PRESSED: if `s`=0, go to DB_RELEASE with cnt←0.
- DB_RELEASE:
  - If `s`=1, return to PRESSED (glitch rejected; `btn_level` stays 1, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE, set `btn_level`←0, and pulse `release_pulse`.
  - Else cnt←cnt+1.
- All outputs are registered. The pulses are never high on two consecutive cycles.
- `press_pulse` and `release_pulse` are never high on the same cycle.
- The counter does not wrap; it is reset on every state entry that needs it.

## Timing
- Reset values: state IDLE, both synchroniser flops 0 (not pressed), cnt 0, hold counter 0, all four outputs 0.
- Press latency: the first `clk` edge that samples `btn_n`=0 is E0. If the input then stays stable, `btn_level` and `press_pulse` go high after edge E(DEBOUNCE_CYCLES+2). Release latency is the same.
- With DEBOUNCE_CYCLES=1: DB_PRESS lasts one cycle, so latency is 3 edges.
- Any level change of `s` during a debounce state aborts the debounce. Timing restarts from the next stable edge.
- Reset asserted mid-operation (any state) forces all reset values on the next edge. No pulse is emitted that cycle.
- If the button is still held when reset is released, a fresh `press_pulse` fires DEBOUNCE_CYCLES+2 edges after reset deassertion.

## Configuration
- Macro: `BUTTON_CONDITIONER_LONG_PRESS_EN`.
- When defined:
  - The hold counter clears to 0 on the PRESSED entry that comes from DB_PRESS.
  - It increments in PRESSED and DB_RELEASE and saturates at HOLD_CYCLES.
  - `long_press` is high for one cycle on the edge where the counter reaches HOLD_CYCLES, and fires at most once per press.
  - The hold counter clears on entry to IDLE.
- When undefined: there is no hold counter logic and `long_press` is constant 0.

## Structure
- Shared package `button_conditioner_pkg` holds:
  - the state encodings IDLE, DB_PRESS, PRESSED and DB_RELEASE;
  - default constants for the 12 MHz clock: debounce 10 ms, hold 1 s.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchroniser with synchronous reset value 0. It will be reused for `go_btn`/`rst_btn` elsewhere.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=20.
- Reset: hold `rst`=1 for 2 cycles with `btn_n`=0. All outputs must stay 0. After `rst` deasserts, `press_pulse` must be high for exactly 1 cycle after the 6th edge, and `btn_level` must stay 1.
- Clean cycle: `btn_n` 1→0 held for 20 cycles, then 0→1. Expect `press_pulse` once at edge 6. After the release, expect `release_pulse` once at edge 6 and `btn_level` must go 0 on that same edge.
- Press bounce: `btn_n` low for 3 cycles, high for 2, low for 3, then high. Expect no pulses and `btn_level` stuck at 0.
- Release glitch: while PRESSED, drive `btn_n` high for 2 cycles, then low again. Expect no `release_pulse` and `btn_level` to stay 1.
- Long press: hold for 40 cycles. With the macro, `long_press` must be high for exactly 1 cycle, 20 cycles after `press_pulse`, and never again. Without the macro it must stay 0 throughout.
- Reset mid-debounce: assert `rst` in DB_PRESS (cnt=2). Expect no `press_pulse` during reset. After release with the button held, expect exactly one `press_pulse` 6 edges later.
